// File: rtl/keccak_chi_sequencer.sv
// Sequencer in front of a masked 32-bit DOM chi S-box: takes one two-share plane and
// one mask word, holds the S-box inputs for its EVAL/HOLD window, and buffers the result.
module keccak_chi_sequencer #(
  parameter int LANE_W     = 32,
  parameter int PLANES     = 5,
  parameter int CLEAR_IDLE = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [5*LANE_W-1:0] in_s0_i,
  input  logic [5*LANE_W-1:0] in_s1_i,
  input  logic                rand_valid_i,
  output logic                rand_ready_o,
  input  logic [LANE_W-1:0]   rand_i,
  output logic [5*LANE_W-1:0] sbox_s0_o,
  output logic [5*LANE_W-1:0] sbox_s1_o,
  output logic [LANE_W-1:0]   sbox_rand_o,
  input  logic [5*LANE_W-1:0] sbox_s0_i,
  input  logic [5*LANE_W-1:0] sbox_s1_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [5*LANE_W-1:0] out_s0_o,
  output logic [5*LANE_W-1:0] out_s1_o,
  output logic [2:0]          plane_idx_o,
  output logic                out_last_o
);
  localparam int PW = 5 * LANE_W;
  localparam logic [2:0] LAST_IDX = 3'(PLANES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RAND = 3'd1,
    S_EVAL = 3'd2,
    S_HOLD = 3'd3,
    S_OUT  = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic [PW-1:0]     s0_q, s0_d, s1_q, s1_d;
  logic [LANE_W-1:0] rand_q, rand_d;
  logic [PW-1:0]     out_s0_q, out_s0_d, out_s1_q, out_s1_d;
  logic [2:0]        idx_q, idx_d;
  logic              drive_en;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid_i) state_d = S_RAND; else state_d = S_IDLE;
      S_RAND:  if (rand_valid_i) state_d = S_EVAL; else state_d = S_RAND;
      S_EVAL:  state_d = S_HOLD;
      S_HOLD:  state_d = S_OUT;
      S_OUT:   if (out_ready_i) state_d = S_IDLE; else state_d = S_OUT;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    in_ready_o   = 1'b0;
    rand_ready_o = 1'b0;
    out_valid_o  = 1'b0;
    drive_en     = 1'b0;
    case (state_q)
      S_IDLE:  in_ready_o   = 1'b1;
      S_RAND:  rand_ready_o = 1'b1;
      S_EVAL:  drive_en     = 1'b1;
      S_HOLD:  drive_en     = 1'b1;
      S_OUT:   out_valid_o  = 1'b1;
      default: in_ready_o   = 1'b0;
    endcase
  end

  // Datapath next values; shares are only moved, never combined
  always_comb begin
    s0_d     = s0_q;
    s1_d     = s1_q;
    rand_d   = rand_q;
    out_s0_d = out_s0_q;
    out_s1_d = out_s1_q;
    idx_d    = idx_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          s0_d = in_s0_i;
          s1_d = in_s1_i;
        end else begin
          s0_d = s0_q;
        end
      end
      S_RAND: begin
        if (rand_valid_i) rand_d = rand_i; else rand_d = rand_q;
      end
      S_HOLD: begin
        out_s0_d = sbox_s0_i;
        out_s1_d = sbox_s1_i;
        if (CLEAR_IDLE != 0) begin
          s0_d   = {PW{1'b0}};
          s1_d   = {PW{1'b0}};
          rand_d = {LANE_W{1'b0}};
        end else begin
          rand_d = rand_q;
        end
      end
      S_OUT: begin
        if (out_ready_i) begin
          idx_d = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
          if (CLEAR_IDLE != 0) begin
            out_s0_d = {PW{1'b0}};
            out_s1_d = {PW{1'b0}};
          end else begin
            out_s0_d = out_s0_q;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: idx_d = idx_q;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s0_q     <= {PW{1'b0}};
      s1_q     <= {PW{1'b0}};
      rand_q   <= {LANE_W{1'b0}};
      out_s0_q <= {PW{1'b0}};
      out_s1_q <= {PW{1'b0}};
      idx_q    <= 3'd0;
    end else begin
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      rand_q   <= rand_d;
      out_s0_q <= out_s0_d;
      out_s1_q <= out_s1_d;
      idx_q    <= idx_d;
    end
  end

  // S-box sees the registered shares only during its two-cycle window
  assign sbox_s0_o   = (drive_en || CLEAR_IDLE == 0) ? s0_q   : {PW{1'b0}};
  assign sbox_s1_o   = (drive_en || CLEAR_IDLE == 0) ? s1_q   : {PW{1'b0}};
  assign sbox_rand_o = (drive_en || CLEAR_IDLE == 0) ? rand_q : {LANE_W{1'b0}};

  assign out_s0_o    = out_s0_q;
  assign out_s1_o    = out_s1_q;
  assign plane_idx_o = idx_q;
  assign out_last_o  = out_valid_o && (idx_q == LAST_IDX);
endmodule

// File: tb/tb_keccak_chi_sequencer.sv
// Bench for keccak_chi_sequencer with a registered DOM chi S-box stub on its S-box ports.
module tb_keccak_chi_sequencer;
  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         in_valid_i = 1'b0, in_ready_o;
  logic [159:0] in_s0_i = 160'd0, in_s1_i = 160'd0;
  logic         rand_valid_i = 1'b0, rand_ready_o;
  logic [31:0]  rand_i = 32'd0;
  logic [159:0] sbox_s0_o, sbox_s1_o, sbox_s0_i, sbox_s1_i;
  logic [31:0]  sbox_rand_o;
  logic         out_valid_o, out_ready_i = 1'b0;
  logic [159:0] out_s0_o, out_s1_o;
  logic [2:0]   plane_idx_o;
  logic         out_last_o;

  int n_tests = 0, n_fail = 0, cons_cnt = 0, exp_idx = 0;
  logic [159:0] last_o0, last_o1;
  logic [319:0] sb_q;

  keccak_chi_sequencer #(.LANE_W(32), .PLANES(5), .CLEAR_IDLE(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_s0_i(in_s0_i), .in_s1_i(in_s1_i),
    .rand_valid_i(rand_valid_i), .rand_ready_o(rand_ready_o), .rand_i(rand_i),
    .sbox_s0_o(sbox_s0_o), .sbox_s1_o(sbox_s1_o), .sbox_rand_o(sbox_rand_o),
    .sbox_s0_i(sbox_s0_i), .sbox_s1_i(sbox_s1_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_s0_o(out_s0_o), .out_s1_o(out_s1_o),
    .plane_idx_o(plane_idx_o), .out_last_o(out_last_o)
  );

  always #5 clk_i = ~clk_i;

  // Plain Keccak chi on an unshared plane: a_x ^= ~a_{x+1} & a_{x+2}
  function automatic logic [159:0] chi_ref(input logic [159:0] p);
    logic [31:0]  l [5];
    logic [159:0] res;
    for (int i = 0; i < 5; i++) l[i] = p[32*i +: 32];
    for (int i = 0; i < 5; i++) res[32*i +: 32] = l[i] ^ (~l[(i+1)%5] & l[(i+2)%5]);
    return res;
  endfunction

  // DOM-masked chi: returns {share1, share0}
  function automatic logic [319:0] dom_chi(input logic [159:0] a0, a1, input logic [31:0] r);
    logic [159:0] o0, o1;
    logic [31:0]  x0, x1, y0, y1;
    for (int i = 0; i < 5; i++) begin
      x0 = a0[32*((i+1)%5) +: 32]; x1 = a1[32*((i+1)%5) +: 32];
      y0 = a0[32*((i+2)%5) +: 32]; y1 = a1[32*((i+2)%5) +: 32];
      o0[32*i +: 32] = a0[32*i +: 32] ^ (~x0 & y0) ^ ((~x0 & y1) ^ r);
      o1[32*i +: 32] = a1[32*i +: 32] ^ (x1 & y1) ^ ((x1 & y0) ^ r);
    end
    return {o1, o0};
  endfunction

  function automatic logic [159:0] rand160();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // S-box stub: one DOM register stage, synchronous reset from ~rst_ni
  always @(posedge clk_i) begin
    if (!rst_ni) sb_q <= 320'd0;
    else         sb_q <= dom_chi(sbox_s0_o, sbox_s1_o, sbox_rand_o);
  end
  assign sbox_s0_i = sb_q[159:0];
  assign sbox_s1_i = sb_q[319:160];

  always @(posedge clk_i) begin
    if (rst_ni && rand_valid_i && rand_ready_o) cons_cnt <= cons_cnt + 1;
  end

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ne(input string name, input logic [159:0] act, input logic [159:0] bad);
    n_tests++;
    if (act === bad) begin
      n_fail++;
      $display("FAIL %s: got %h which must differ from %h", name, act, bad);
    end
  endtask

  task automatic chk_sbox_idle(input string name);
    chk({name, "_sbox_s0"}, sbox_s0_o, 160'd0);
    chk({name, "_sbox_s1"}, sbox_s1_o, 160'd0);
    chk({name, "_sbox_rand"}, {128'd0, sbox_rand_o}, 160'd0);
  endtask

  // Entered at a negedge with the DUT idle; returns at the negedge of the next idle cycle
  task automatic run_plane(input logic [159:0] s0, s1, input logic [31:0] r,
                           input int rdly, input int odly);
    logic [159:0] plain;
    logic [319:0] sh;
    int c0;
    plain = chi_ref(s0 ^ s1);
    sh    = dom_chi(s0, s1, r);
    chk("idle_in_ready", {159'd0, in_ready_o}, 160'd1);
    chk_sbox_idle("idle");
    in_valid_i = 1'b1; in_s0_i = s0; in_s1_i = s1;
    c0 = cons_cnt;
    @(negedge clk_i);
    in_valid_i = 1'b0; in_s0_i = rand160(); in_s1_i = rand160();
    for (int k = 0; k < rdly; k++) begin
      chk("stall_rand_ready", {159'd0, rand_ready_o}, 160'd1);
      chk("stall_out_valid", {159'd0, out_valid_o}, 160'd0);
      chk_sbox_idle("stall");
      rand_i = $urandom;
      @(negedge clk_i);
    end
    chk("rand_ready", {159'd0, rand_ready_o}, 160'd1);
    chk_sbox_idle("rand");
    rand_valid_i = 1'b1; rand_i = r;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      rand_valid_i = 1'b0; rand_i = $urandom;
      chk("eval_rand_ready", {159'd0, rand_ready_o}, 160'd0);
      chk("eval_out_valid", {159'd0, out_valid_o}, 160'd0);
      chk("eval_sbox_s0", sbox_s0_o, s0);
      chk("eval_sbox_s1", sbox_s1_o, s1);
      chk("eval_sbox_rand", {128'd0, sbox_rand_o}, {128'd0, r});
    end
    @(negedge clk_i);
    chk("out_valid_latency", {159'd0, out_valid_o}, 160'd1);
    chk("out_s0", out_s0_o, sh[159:0]);
    chk("out_s1", out_s1_o, sh[319:160]);
    chk("out_plain", out_s0_o ^ out_s1_o, plain);
    chk("plane_idx", {157'd0, plane_idx_o}, 160'(exp_idx));
    chk("out_last", {159'd0, out_last_o}, {159'd0, exp_idx == 4});
    chk("rand_consumed_once", 160'(cons_cnt - c0), 160'd1);
    last_o0 = out_s0_o; last_o1 = out_s1_o;
    for (int k = 0; k < odly; k++) begin
      @(negedge clk_i);
      chk("hold_out_valid", {159'd0, out_valid_o}, 160'd1);
      chk("hold_out_s0", out_s0_o, last_o0);
      chk("hold_out_s1", out_s1_o, last_o1);
      chk("hold_in_ready", {159'd0, in_ready_o}, 160'd0);
      chk_sbox_idle("hold");
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    exp_idx = (exp_idx + 1) % 5;
    chk("post_out_valid", {159'd0, out_valid_o}, 160'd0);
    chk("post_out_s0_clear", out_s0_o, 160'd0);
    chk("post_out_s1_clear", out_s1_o, 160'd0);
    chk("post_plane_idx", {157'd0, plane_idx_o}, 160'(exp_idx));
  endtask

  typedef struct {
    logic [159:0] s0, s1, plain;
    logic [31:0]  r;
    int           rdly, odly;
    bit           masked;
  } vec_t;

  vec_t vt [4];
  logic [159:0] pin, msk;

  initial begin
    pin = {32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0};
    msk = {32'h55555555, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h9ABCDEF0, 32'h12345678};
    vt[0] = '{s0: pin, s1: 160'd0, plain: {32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF},
              r: 32'h0, rdly: 0, odly: 0, masked: 1'b0};
    vt[1] = '{s0: pin ^ msk, s1: msk, plain: {32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF},
              r: 32'hDEADBEEF, rdly: 0, odly: 0, masked: 1'b1};
    vt[2] = '{s0: pin, s1: 160'd0, plain: {32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF},
              r: 32'h0, rdly: 7, odly: 0, masked: 1'b0};
    vt[3] = '{s0: pin ^ msk, s1: msk, plain: {32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF},
              r: 32'hDEADBEEF, rdly: 0, odly: 10, masked: 1'b1};

    repeat (3) @(negedge clk_i);
    chk("rst_in_ready", {159'd0, in_ready_o}, 160'd1);
    chk("rst_rand_ready", {159'd0, rand_ready_o}, 160'd0);
    chk("rst_out_valid", {159'd0, out_valid_o}, 160'd0);
    chk("rst_out_s0", out_s0_o, 160'd0);
    chk("rst_plane_idx", {157'd0, plane_idx_o}, 160'd0);
    chk_sbox_idle("rst");
    rst_ni = 1'b1;

    for (int i = 0; i < 4; i++) begin
      run_plane(vt[i].s0, vt[i].s1, vt[i].r, vt[i].rdly, vt[i].odly);
      chk("tbl_plain", last_o0 ^ last_o1, vt[i].plain);
      if (vt[i].masked) begin
        chk_ne("tbl_share0_masked", last_o0, vt[i].plain);
        chk_ne("tbl_share1_masked", last_o1, vt[i].plain);
      end
    end

    // Back-to-back randomized planes walk plane_idx through its wrap several times
    for (int i = 0; i < 20; i++) run_plane(rand160(), rand160(), $urandom, 0, 0);

    // Reset pulse during HOLD abandons the plane
    in_valid_i = 1'b1; in_s0_i = rand160(); in_s1_i = rand160();
    @(negedge clk_i);
    in_valid_i = 1'b0; rand_valid_i = 1'b1; rand_i = $urandom;
    @(negedge clk_i);
    rand_valid_i = 1'b0;
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_in_ready", {159'd0, in_ready_o}, 160'd1);
    chk("arst_rand_ready", {159'd0, rand_ready_o}, 160'd0);
    chk("arst_out_valid", {159'd0, out_valid_o}, 160'd0);
    chk("arst_out_s0", out_s0_o, 160'd0);
    chk("arst_out_s1", out_s1_o, 160'd0);
    chk("arst_plane_idx", {157'd0, plane_idx_o}, 160'd0);
    chk_sbox_idle("arst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    exp_idx = 0;
    for (int i = 0; i < 3; i++)
      run_plane(rand160(), rand160(), $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/keccak_chi_sequencer.md
Name: keccak_chi_sequencer

Overview:
- Control and buffering stage directly upstream of the masked 32-bit DOM chi S-box; also consumes that S-box's output.
- Accepts one two-share Keccak plane (lanes A..E) per handshake and takes one fresh 32-bit mask word from the PRNG.
- Drives the S-box with stable shares and randomness for exactly the two cycles its DOM register needs, then captures the result into an output buffer.
- Keeps S-box inputs zeroed when idle, and tracks the plane index within a round.

Parameters:
- LANE_W, 32, lane width in bits; only 32 is supported, to match the S-box.
- PLANES, 5, planes per round; the plane counter wraps at PLANES-1.
- CLEAR_IDLE, 1, when 1, zero S-box drive and clear consumed input/rand registers outside EVAL/HOLD.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  input plane valid
- in_ready_o  out  1  block can accept a plane
- in_s0_i  in  160  share 0; A=[31:0], B=[63:32], C=[95:64], D=[127:96], E=[159:128]
- in_s1_i  in  160  share 1, same packing
- rand_valid_i  in  1  PRNG word valid
- rand_ready_o  out  1  PRNG word consumed this cycle
- rand_i  in  32  fresh mask word
- sbox_s0_o  out  160  share 0 to S-box A0..E0 inputs
- sbox_s1_o  out  160  share 1 to S-box A1..E1 inputs
- sbox_rand_o  out  32  to S-box rand input
- sbox_s0_i  in  160  S-box share-0 outputs, same packing
- sbox_s1_i  in  160  S-box share-1 outputs
- out_valid_o  out  1  result plane valid
- out_ready_i  in  1  downstream accepts result
- out_s0_o  out  160  result share 0 (registered)
- out_s1_o  out  160  result share 1 (registered)
- plane_idx_o  out  3  index of the plane currently in flight or held, 0..PLANES-1
- out_last_o  out  1  out_valid_o && plane_idx_o==PLANES-1

Behaviour:
- Reset (async, rst_ni low): state IDLE; all share, rand and output registers 0; plane_idx 0.
  - Reset values: in_ready_o=1, rand_ready_o=0, out_valid_o=0, all data outputs 0.
  - Reset mid-operation abandons the plane with no partial output. The S-box's own synchronous reset is driven by the integrator from ~rst_ni.
- FSM states: IDLE, RAND, EVAL, HOLD, OUT. One plane in flight at a time; no overlap, so no transition mixing between planes.
- IDLE: in_ready_o=1. On in_valid_i, latch in_s0_i/in_s1_i and go to RAND.
- RAND: rand_ready_o = 1 for as long as the block is in RAND (stall indefinitely).
  - On rand_valid_i, latch rand_i and go to EVAL. rand_ready_o && rand_valid_i is the consume event.
  - A word is never reused for two planes.
- EVAL: sbox_s0_o/sbox_s1_o/sbox_rand_o driven from registers. The S-box DOM register samples at the end of this cycle. Go to HOLD.
- HOLD: same drive, unchanged. At the end of the cycle, latch sbox_s0_i/sbox_s1_i into out_s0/out_s1; go to OUT.
- OUT: out_valid_o=1. Data is stable while out_ready_i is low.
  - On out_ready_i, go to IDLE and increment plane_idx (PLANES-1 wraps to 0).
- Outside EVAL/HOLD, with CLEAR_IDLE=1:
  - sbox_* outputs are 0.
  - Share and rand registers are cleared on leaving HOLD.
  - Output registers are cleared on the out handshake.
- With CLEAR_IDLE=0, registers and drive hold their last values.
- Latency: accept at cycle t, rand present at t+1 → out_valid_o first high at t+4. Minimum 5 cycles per plane, including the return to IDLE.
- in_ready_o is high only in IDLE, so in_valid_i asserted during OUT waits.
- Shares are never combined inside the block: no XOR of s0 with s1 anywhere.

Test Plan:
- Unmasked-equivalent plane, s1=0; s0: A=0, B=0, C=FFFFFFFF, D=0, E=0; rand=0 → out_s0^out_s1 gives A=FFFFFFFF, B=0, C=FFFFFFFF, D=0, E=0; out_valid_o at t+4.
- Same plane re-masked with s1 lanes 12345678, 9ABCDEF0, 0F0F0F0F, F0F0F0F0, 55555555 (s0 XORed accordingly), rand=DEADBEEF → identical unshared result; no share equals the plain value.
- rand_valid_i held low for 7 cycles after accept → rand_ready_o high for the whole stall; sbox_* stays 0; out_valid_o at t+11; exactly one rand consumed.
- out_ready_i low for 10 cycles in OUT → outputs stable and in_ready_o=0. Then 5 back-to-back planes → plane_idx_o 0..4, out_last_o only on the 5th, then wraps to 0.
- rst_ni pulsed low during HOLD → all outputs 0 immediately (async) and state IDLE. The next plane completes correctly with plane_idx_o=0.
- CLEAR_IDLE=1: sbox_s0_o, sbox_s1_o and sbox_rand_o are nonzero only in the EVAL/HOLD cycles, checked cycle-by-cycle over 3 planes.
